// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one pipelined ALU between two requesters.
// Each issued op carries an owner tag so that its result is returned to the requester that issued it.
module alu_arbiter #(
   parameter int ALU_LATENCY = 2,
   parameter int DW          = 8,
   parameter int RW          = 16
) (
   input  logic          clk_p_i,
   input  logic          reset_p_i,
   input  logic          hold_i,
   input  logic          req0_valid_i,
   input  logic [2:0]    req0_inst_i,
   input  logic [DW-1:0] req0_a_i,
   input  logic [DW-1:0] req0_b_i,
   output logic          req0_ready_o,
   input  logic          req1_valid_i,
   input  logic [2:0]    req1_inst_i,
   input  logic [DW-1:0] req1_a_i,
   input  logic [DW-1:0] req1_b_i,
   output logic          req1_ready_o,
   output logic          rsp0_valid_o,
   output logic [RW-1:0] rsp0_data_o,
   output logic          rsp1_valid_o,
   output logic [RW-1:0] rsp1_data_o,
   output logic [DW-1:0] alu_a_o,
   output logic [DW-1:0] alu_b_o,
   output logic [2:0]    alu_inst_o,
   input  logic [RW-1:0] alu_data_i,
   output logic          idle_o
);

   logic                 last;        // 1: requester 1 won the most recent handshake
   logic                 grant0;
   logic                 grant1;
   logic                 fire;
   logic [ALU_LATENCY:0] tag_valid;
   logic [ALU_LATENCY:0] tag_owner;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset_p_i && !hold_i) begin
         if (req0_valid_i && (!req1_valid_i || last))
            grant0 = 1'b1;
         else if (req1_valid_i)
            grant1 = 1'b1;
      end
   end

   assign fire         = grant0 | grant1;
   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;

   always_ff @(posedge clk_p_i) begin
      if (reset_p_i) begin
         last         <= 1'b1;
         alu_a_o      <= '0;
         alu_b_o      <= '0;
         alu_inst_o   <= '0;
         tag_valid    <= '0;
         tag_owner    <= '0;
         rsp0_valid_o <= 1'b0;
         rsp1_valid_o <= 1'b0;
         rsp0_data_o  <= '0;
         rsp1_data_o  <= '0;
      end else begin
         alu_a_o    <= '0;
         alu_b_o    <= '0;
         alu_inst_o <= '0;
         if (grant0) begin
            alu_a_o    <= req0_a_i;
            alu_b_o    <= req0_b_i;
            alu_inst_o <= req0_inst_i;
            last       <= 1'b0;
         end else if (grant1) begin
            alu_a_o    <= req1_a_i;
            alu_b_o    <= req1_b_i;
            alu_inst_o <= req1_inst_i;
            last       <= 1'b1;
         end

         // The tag pipeline advances every cycle, so it tracks the ALU even while hold_i is high.
         tag_valid <= {tag_valid[ALU_LATENCY-1:0], fire};
         tag_owner <= {tag_owner[ALU_LATENCY-1:0], grant1};

         rsp0_valid_o <= tag_valid[ALU_LATENCY] & ~tag_owner[ALU_LATENCY];
         rsp1_valid_o <= tag_valid[ALU_LATENCY] &  tag_owner[ALU_LATENCY];
         if (tag_valid[ALU_LATENCY] && !tag_owner[ALU_LATENCY])
            rsp0_data_o <= alu_data_i;
         if (tag_valid[ALU_LATENCY] && tag_owner[ALU_LATENCY])
            rsp1_data_o <= alu_data_i;
      end
   end

   assign idle_o = ~|tag_valid & ~rsp0_valid_o & ~rsp1_valid_o & ~fire;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a 2-cycle behavioural ALU plus a transaction-level reference model
// (grant pointer and a queue of pending responses with due cycles).
module tb_alu_arbiter;
   localparam int LAT = 2;
   localparam int DW  = 8;
   localparam int RW  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, hold, v0, v1;
   logic [2:0]    i0, i1;
   logic [DW-1:0] a0, b0, a1, b1;
   logic          rdy0, rdy1, rv0, rv1, idle;
   logic [RW-1:0] rd0, rd1;
   logic [DW-1:0] alu_a, alu_b;
   logic [2:0]    alu_inst;
   logic [RW-1:0] alu_data = '0;
   logic [RW-1:0] alu_s1   = '0;

   alu_arbiter #(.ALU_LATENCY(LAT), .DW(DW), .RW(RW)) dut (
      .clk_p_i(clk), .reset_p_i(rst), .hold_i(hold),
      .req0_valid_i(v0), .req0_inst_i(i0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(rdy0),
      .req1_valid_i(v1), .req1_inst_i(i1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(rdy1),
      .rsp0_valid_o(rv0), .rsp0_data_o(rd0), .rsp1_valid_o(rv1), .rsp1_data_o(rd1),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_inst_o(alu_inst), .alu_data_i(alu_data),
      .idle_o(idle)
   );

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int          sa;
      logic [31:0] d;
      case (op)
         3'b111: return 16'(a) + 16'(b);
         3'b001: return 16'(b) - 16'(a);
         3'b010: return 16'(a) * 16'(b);
         3'b011: return {8'h00, ~a};
         3'b100: return {8'h00, a ^ b};
         3'b101: begin
            sa = int'($signed(a));
            return (sa < 0) ? 16'(-sa) : 16'(sa);
         end
         3'b110: begin
            d = 32'(int'(b) - int'(a));
            return d[16:1];
         end
         default: return 16'h0000;
      endcase
   endfunction

   // Environment ALU: operands present in cycle N+1, result on alu_data in cycle N+3.
   always @(posedge clk) begin
      alu_s1   <= alu_f(alu_inst, alu_a, alu_b);
      alu_data <= alu_s1;
   end

   typedef struct {
      int          due;
      bit          owner;
      logic [15:0] data;
   } pend_t;

   pend_t       q[$];
   int          cyc = 0;
   bit          started = 1'b0;
   bit          last;
   bit          g0, g1;
   logic [2:0]  e_inst;
   logic [7:0]  e_a, e_b;
   bit   [1:0]  e_rv;
   logic [15:0] e_rd [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic          nx_rst = 1'b0, nx_hold = 1'b0, nx_v0 = 1'b0, nx_v1 = 1'b0;
   logic [2:0]    nx_i0 = '0, nx_i1 = '0;
   logic [DW-1:0] nx_a0 = '0, nx_b0 = '0, nx_a1 = '0, nx_b1 = '0;
   logic [7:0]    absv [8] = '{8'h80, 8'hFF, 8'h05, 8'h7F, 8'h81, 8'h00, 8'h01, 8'hC0};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: check registered outputs, drive inputs, check grants/idle, then advance the model.
   task automatic step();
      pend_t p;
      @(negedge clk);
      if (started) begin
         check("alu_inst", 32'(alu_inst), 32'(e_inst));
         check("alu_a", 32'(alu_a), 32'(e_a));
         check("alu_b", 32'(alu_b), 32'(e_b));
         check("rsp0_valid", 32'(rv0), 32'(e_rv[0]));
         check("rsp1_valid", 32'(rv1), 32'(e_rv[1]));
         check("rsp0_data", 32'(rd0), 32'(e_rd[0]));
         check("rsp1_data", 32'(rd1), 32'(e_rd[1]));
      end
      rst = nx_rst; hold = nx_hold;
      v0 = nx_v0; i0 = nx_i0; a0 = nx_a0; b0 = nx_b0;
      v1 = nx_v1; i1 = nx_i1; a1 = nx_a1; b1 = nx_b1;
      #1;
      g0 = !rst && !hold && v0 && (!v1 || last);
      g1 = !rst && !hold && v1 && !g0;
      if (started) begin
         check("req0_ready", 32'(rdy0), 32'(g0));
         check("req1_ready", 32'(rdy1), 32'(g1));
         check("idle", 32'(idle), 32'(q.size() == 0 && e_rv == 2'b00 && !(g0 || g1)));
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
         last = 1'b1; e_inst = '0; e_a = '0; e_b = '0; e_rv = '0;
         e_rd[0] = '0; e_rd[1] = '0;
         started = 1'b1;
         cyc++;
      end else begin
         e_inst = '0; e_a = '0; e_b = '0;
         if (g0 || g1) begin
            e_inst = g0 ? i0 : i1;
            e_a    = g0 ? a0 : a1;
            e_b    = g0 ? b0 : b1;
            last   = g1;
            q.push_back('{due: cyc + LAT + 2, owner: g1, data: alu_f(e_inst, e_a, e_b)});
         end
         cyc++;
         e_rv = '0;
         if (q.size() > 0 && q[0].due == cyc) begin
            p = q.pop_front();
            e_rv[p.owner] = 1'b1;
            e_rd[p.owner] = p.data;
         end
      end
   endtask

   initial begin
      last = 1'b1;
      nx_rst = 1'b1; step(); step(); nx_rst = 1'b0;

      // single op latency
      nx_v0 = 1'b1; nx_i0 = 3'b111; nx_a0 = 8'd3; nx_b0 = 8'd5; step();
      nx_v0 = 1'b0; repeat (6) step();

      // contention fairness, starting from a fresh pointer
      nx_rst = 1'b1; step(); nx_rst = 1'b0;
      nx_v0 = 1'b1; nx_i0 = 3'b010; nx_a0 = 8'd255; nx_b0 = 8'd255;
      nx_v1 = 1'b1; nx_i1 = 3'b001; nx_a1 = 8'd5;   nx_b1 = 8'd3;
      repeat (8) step();
      nx_v0 = 1'b0; nx_v1 = 1'b0; repeat (6) step();

      // back-to-back throughput from requester 1
      nx_v1 = 1'b1; nx_i1 = 3'b101;
      for (int i = 0; i < 8; i++) begin
         nx_a1 = absv[i]; nx_b1 = 8'(i); step();
      end
      nx_v1 = 1'b0; repeat (7) step();

      // hold with an op in flight
      nx_v0 = 1'b1; nx_i0 = 3'b110; nx_a0 = 8'd3; nx_b0 = 8'd9; step();
      nx_hold = 1'b1; nx_i0 = 3'b111; nx_a0 = 8'd1; nx_b0 = 8'd2;
      nx_v1 = 1'b1; nx_i1 = 3'b100; nx_a1 = 8'h5A; nx_b1 = 8'h0F;
      repeat (3) step();
      nx_hold = 1'b0; step(); step();
      nx_v0 = 1'b0; nx_v1 = 1'b0; repeat (6) step();

      // reset mid-flight
      nx_v0 = 1'b1; nx_i0 = 3'b111; nx_a0 = 8'd10; nx_b0 = 8'd20; step();
      nx_v0 = 1'b0; nx_v1 = 1'b1; nx_i1 = 3'b010; nx_a1 = 8'd7; nx_b1 = 8'd9; step();
      nx_v1 = 1'b0; step();
      nx_rst = 1'b1; step(); nx_rst = 1'b0;
      nx_v0 = 1'b1; nx_v1 = 1'b1; step();
      nx_v0 = 1'b0; nx_v1 = 1'b0; repeat (6) step();

      // valid withdrawal under hold
      nx_hold = 1'b1; nx_v1 = 1'b1; nx_i1 = 3'b011; nx_a1 = 8'h3C; step();
      nx_v1 = 1'b0; nx_hold = 1'b0; repeat (5) step();

      // randomized traffic, honouring the hold-until-ready rule except for deliberate withdrawals
      for (int c = 0; c < 400; c++) begin
         if (!nx_v0 || g0 || $urandom_range(0, 9) == 0) begin
            nx_v0 = ($urandom_range(0, 2) != 0);
            nx_i0 = 3'($urandom); nx_a0 = 8'($urandom); nx_b0 = 8'($urandom);
         end
         if (!nx_v1 || g1 || $urandom_range(0, 9) == 0) begin
            nx_v1 = ($urandom_range(0, 2) != 0);
            nx_i1 = 3'($urandom); nx_a1 = 8'($urandom); nx_b1 = 8'($urandom);
         end
         nx_hold = ($urandom_range(0, 7) == 0);
         nx_rst  = ($urandom_range(0, 49) == 0);
         step();
      end
      nx_v0 = 1'b0; nx_v1 = 1'b0; nx_hold = 1'b0; nx_rst = 1'b0;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single pipelined ALU (8-bit operands, 3-bit opcode, 16-bit result, fixed 2-cycle latency) between two requesters.
- Uses a valid/ready handshake, round-robin arbitration and registered issue.
- Tracks each in-flight op with an owner tag so the ALU result returns to the requester that issued it.
- Sits between the command sources and the ALU instance. The ALU needs no modification.

Parameters:
- ALU_LATENCY, 2: ALU cycles from operand sample edge to valid data out. Sizes the tag pipeline.
- DW, 8: operand width.
- RW, 16: result width.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_p_i  in  1  synchronous, active-high reset.
- hold_i  in  1  when high, no new issue; in-flight ops complete.
- req0_valid_i  in  1  requester 0 has an op.
- req0_inst_i  in  3  opcode.
- req0_a_i  in  DW  operand A.
- req0_b_i  in  DW  operand B.
- req0_ready_o  out  1  grant; the op is accepted this cycle when valid&ready.
- req1_valid_i, req1_inst_i, req1_a_i, req1_b_i, req1_ready_o: same as requester 0.
- rsp0_valid_o  out  1  one-cycle pulse, result for requester 0.
- rsp0_data_o  out  RW  result.
- rsp1_valid_o  out  1  one-cycle pulse, result for requester 1.
- rsp1_data_o  out  RW  result.
- alu_a_o  out  DW  to ALU data_a.
- alu_b_o  out  DW  to ALU data_b.
- alu_inst_o  out  3  to ALU inst.
- alu_data_i  in  RW  from ALU data_o.
- idle_o  out  1  no op in flight and no issue pending.

Behaviour:
- Reset (reset_p_i high at a rising edge):
  - alu_a_o, alu_b_o and alu_inst_o go to 0 (opcode 000 = no-op, result ignored).
  - rsp*_valid_o go to 0 and rsp*_data_o go to 0.
  - The tag pipeline is cleared.
  - Last-grant pointer is set to 1, so requester 0 wins first.
  - idle_o goes to 1.
  - req*_ready_o are forced to 0 while reset_p_i is high.
- Reset mid-operation: all in-flight ops are dropped. No response pulse appears for them, even after reset is released.
- Grant (combinational from the valids, hold_i and the pointer):
  - Both readies are 0 when hold_i=1 or reset_p_i=1.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last time gets ready=1. At most one ready is high per cycle.
  - The pointer updates only on an actual handshake.
- Requester rules:
  - A requester must hold valid and its operands stable until it sees ready.
  - Dropping valid before ready is allowed; nothing is issued.
- Issue: on handshake in cycle N, the granted operands and opcode are registered onto alu_*_o at the end of N, so they are present in cycle N+1. With no handshake, alu_inst_o=000 and alu_a_o/alu_b_o=0 in the next cycle.
- Tag pipeline:
  - Shift register of depth ALU_LATENCY+1, entries {valid, owner}.
  - Entry injected with the issue and advances every cycle, including while hold_i=1.
- Response:
  - In cycle N+ALU_LATENCY+1, alu_data_i is registered into rsp{owner}_data_o and rsp{owner}_valid_o pulses in cycle N+ALU_LATENCY+2, i.e. N+4 at default.
  - The non-owner rsp_valid stays 0 and its data register holds its previous value.
  - Responses cannot be back-pressured.
- Throughput:
  - One issue per cycle sustained; back-to-back responses appear in consecutive cycles in issue order.
  - Any opcode is forwarded unchanged, including 000; the result for 000 is whatever the ALU returns.
- idle_o = no tag entry valid and no rsp pulse this cycle and no valid&ready this cycle.
- Arithmetic: the block never modifies data. Results are those of the ALU:
  - 111: A+B.
  - 001: B-A, 16-bit two's complement.
  - 010: A*B.
  - 011: ~A, 8-bit zero-extended.
  - 100: A^B.
  - 101: |A| (A signed).
  - 110: (B-A)>>1 on the 32-bit difference, low 16 bits.

Test Plan:
- Single op latency: after reset, req0 inst=111, a=3, b=5, handshake cycle N -> alu_inst_o=111 in N+1; rsp0_valid_o=1 with rsp0_data_o=16'h0008 in N+4 only; rsp1_valid_o stays 0.
- Contention fairness: both valid continuously from the cycle after reset, req0 inst=010 a=255 b=255, req1 inst=001 a=5 b=3 -> grants alternate 0,1,0,1; rsp0=16'hFE01 and rsp1=16'hFFFE pulses alternate in consecutive cycles.
- Back-to-back throughput: req1 alone issues 8 ops in 8 consecutive cycles, inst=101 with a=8'h80, 8'hFF, 8'h05, ... -> 8 consecutive rsp1 pulses in order, starting 16'h0080, 16'h0001, 16'h0005, ...; idle_o=0 throughout and 1 one cycle after the last pulse.
- Hold: assert hold_i one cycle after a req0 handshake (inst=110, a=3, b=9) -> both readies 0 during hold; the in-flight op still returns rsp0=16'h0003 on time; issue resumes the cycle hold_i drops.
- Reset mid-flight: issue 2 ops, assert reset_p_i one cycle later for 1 cycle -> no rsp pulses at any later cycle; all outputs at reset values; next grant goes to req0 when both are valid.
- Valid withdrawal: req1 valid for one cycle while hold_i=1, then dropped -> nothing issued, alu_inst_o stays 000, no rsp1 pulse.
